// File: rtl/tipi_mailbox_ctrl_if.sv
// TIPI mailbox bus bundle: TI expansion-bus side and RPi side of the mailbox.
// TI-side vectors use TI bit numbering (bit 0 = MSB).
`timescale 1ns/1ps
interface tipi_mailbox_ctrl_if;
  logic [0:15] ti_a;
  logic [0:7]  ti_data;
  logic        ti_memen;
  logic        ti_we;
  logic        ti_dbin;
  logic        ti_cruclk;
  logic        ti_reset;
  logic [3:0]  cru_base;
  logic        rpi_wr;
  logic        rpi_sel;
  logic [7:0]  rpi_wdata;
  logic        rpi_tc_ack;
  logic [7:0]  rpi_td;
  logic [7:0]  rpi_tc;
  logic        rpi_tc_new;
  logic [0:7]  ti_rdata;
  logic        crubit;
  logic        tipi_data_out;
  logic        tipi_control_out;
  logic        tipi_dsr_out;

  modport slave (
    input  ti_a, ti_data, ti_memen, ti_we, ti_dbin, ti_cruclk, ti_reset, cru_base,
    input  rpi_wr, rpi_sel, rpi_wdata, rpi_tc_ack,
    output rpi_td, rpi_tc, rpi_tc_new, ti_rdata, crubit,
    output tipi_data_out, tipi_control_out, tipi_dsr_out
  );

  modport master (
    output ti_a, ti_data, ti_memen, ti_we, ti_dbin, ti_cruclk, ti_reset, cru_base,
    output rpi_wr, rpi_sel, rpi_wdata, rpi_tc_ack,
    input  rpi_td, rpi_tc, rpi_tc_new, ti_rdata, crubit,
    input  tipi_data_out, tipi_control_out, tipi_dsr_out
  );
endinterface

// File: rtl/tipi_mailbox_ctrl.sv
// TIPI mailbox controller: synchronizes TI strobes into clk, owns the CRU
// enable bit and the TD/TC/RD/RC mailbox registers, drives the transceiver
// OE* lines and the TC-written notification towards the RPi.
`timescale 1ns/1ps
module tipi_mailbox_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ADDR_TD     = 16'h5FFF,
  parameter logic [15:0] ADDR_TC     = 16'h5FFD,
  parameter logic [15:0] ADDR_RD     = 16'h5FFB,
  parameter logic [15:0] ADDR_RC     = 16'h5FF9,
  parameter logic [15:0] DSR_LAST    = 16'h5FF7
) (
  input  logic                clk,
  input  logic                rst_n,
  tipi_mailbox_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Strobe vector order: {memen, we, dbin, cruclk, reset}; idle levels below.
  localparam logic [4:0] STRB_IDLE = 5'b11011;

  logic [4:0]  r_sync [SYNC_STAGES];
  logic        r_we_d;
  logic        r_cruclk_d;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_td, r_tc, r_rd, r_rc, r_rdata;
  logic        r_tc_new, r_crubit;
  logic        r_oe_data, r_oe_ctrl, r_oe_dsr;
  logic        r_pend_vld, r_pend_sel;
  logic [7:0]  r_pend_data;

  logic [4:0]  w_raw, w_strb;
  logic        w_memen_s, w_we_s, w_dbin_s, w_cruclk_s, w_treset_s;
  logic        w_we_fall, w_cru_fall, w_cru_hit;
  logic        w_hit_rd, w_hit_rc, w_hit_dsr, w_read_hit;
  logic        w_enter_read, w_read_exit, w_wr_blocked;

  assign w_raw      = {bus.ti_memen, bus.ti_we, bus.ti_dbin, bus.ti_cruclk, bus.ti_reset};
  assign w_strb     = r_sync[SYNC_STAGES-1];
  assign w_memen_s  = w_strb[4];
  assign w_we_s     = w_strb[3];
  assign w_dbin_s   = w_strb[2];
  assign w_cruclk_s = w_strb[1];
  assign w_treset_s = w_strb[0];
  assign w_we_fall  = r_we_d & ~w_we_s;
  assign w_cru_fall = r_cruclk_d & ~w_cruclk_s;

  // CRU bit address: 0001 nnnn 0000000 b  (n = cru_base, b = value)
  assign w_cru_hit  = (r_addr[15:12] == 4'h1) && (r_addr[11:8] == bus.cru_base) &&
                      (r_addr[7:1] == 7'd0);
  assign w_hit_rd   = (r_addr == ADDR_RD);
  assign w_hit_rc   = (r_addr == ADDR_RC);
  assign w_hit_dsr  = (r_addr >= 16'h4000) && (r_addr <= DSR_LAST) && !w_hit_rd && !w_hit_rc;
  assign w_read_hit = w_hit_rd | w_hit_rc | w_hit_dsr;

  assign w_enter_read = (r_state == ST_IDLE) && (w_state_nxt == ST_READ);
  assign w_read_exit  = (r_state == ST_READ) && (w_state_nxt != ST_READ);
  // An RPi write to the register currently being driven to the TI is deferred.
  assign w_wr_blocked = bus.rpi_wr && (r_state == ST_READ) && !w_read_exit &&
                        ((!bus.rpi_sel && !r_oe_data) || (bus.rpi_sel && !r_oe_ctrl));

  // Strobe synchronizer chains, reset to the inactive strobe levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= STRB_IDLE;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Edge-detect history and single registration of address/data buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_d     <= 1'b1;
      r_cruclk_d <= 1'b1;
      r_addr     <= 16'h0000;
      r_data     <= 8'h00;
    end else begin
      r_we_d     <= w_we_s;
      r_cruclk_d <= w_cruclk_s;
      r_addr     <= bus.ti_a;
      r_data     <= bus.ti_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: HOLD waits for the strobe to end so one strobe captures once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_memen_s && w_we_fall && r_crubit)                    w_state_nxt = ST_WRITE;
        else if (!w_memen_s && w_dbin_s && r_crubit && w_read_hit)  w_state_nxt = ST_READ;
        else                                                        w_state_nxt = ST_IDLE;
      end
      ST_WRITE: w_state_nxt = ST_HOLD;
      ST_READ: begin
        if (w_memen_s || !w_dbin_s) w_state_nxt = ST_HOLD;
        else                        w_state_nxt = ST_READ;
      end
      ST_HOLD: begin
        if (w_we_s && w_memen_s) w_state_nxt = ST_IDLE;
        else                     w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // TI-owned registers; synchronized TI reset clears them but not RD/RC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crubit <= 1'b0;
      r_td     <= 8'h00;
      r_tc     <= 8'h00;
      r_tc_new <= 1'b0;
    end else if (!w_treset_s) begin
      r_crubit <= 1'b0;
      r_td     <= 8'h00;
      r_tc     <= 8'h00;
      r_tc_new <= 1'b0;
    end else begin
      if (w_cru_fall && w_cru_hit) r_crubit <= r_addr[0];
      if ((r_state == ST_WRITE) && (r_addr == ADDR_TD)) r_td <= r_data;
      // A TC write in the same cycle as an ack keeps the flag set.
      if ((r_state == ST_WRITE) && (r_addr == ADDR_TC)) begin
        r_tc     <= r_data;
        r_tc_new <= 1'b1;
      end else if (bus.rpi_tc_ack) begin
        r_tc_new <= 1'b0;
      end
    end
  end

  // One-entry pending buffer for RPi writes that hit the register being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_sel  <= 1'b0;
      r_pend_data <= 8'h00;
    end else if (w_wr_blocked) begin
      r_pend_vld  <= 1'b1;
      r_pend_sel  <= bus.rpi_sel;
      r_pend_data <= bus.rpi_wdata;
    end else if (w_read_exit) begin
      r_pend_vld  <= 1'b0;
    end
  end

  // RD/RC update: drain pending on READ exit, then a direct write (newer) wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= 8'h00;
      r_rc <= 8'h00;
    end else begin
      if (w_read_exit && r_pend_vld) begin
        if (r_pend_sel) r_rc <= r_pend_data;
        else            r_rd <= r_pend_data;
      end
      if (bus.rpi_wr && !w_wr_blocked) begin
        if (bus.rpi_sel) r_rc <= bus.rpi_wdata;
        else             r_rd <= bus.rpi_wdata;
      end
    end
  end

  // Read data follows the addressed RD/RC except while READ, where it is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_rdata <= 8'h00;
    else if (r_state != ST_READ) r_rdata <= w_hit_rc ? r_rc : r_rd;
  end

  // Transceiver OE*: one line low only while in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oe_data <= 1'b1;
      r_oe_ctrl <= 1'b1;
      r_oe_dsr  <= 1'b1;
    end else if (w_enter_read) begin
      r_oe_data <= ~w_hit_rd;
      r_oe_ctrl <= ~w_hit_rc;
      r_oe_dsr  <= ~w_hit_dsr;
    end else if (w_state_nxt != ST_READ) begin
      r_oe_data <= 1'b1;
      r_oe_ctrl <= 1'b1;
      r_oe_dsr  <= 1'b1;
    end
  end

  assign bus.rpi_td           = r_td;
  assign bus.rpi_tc           = r_tc;
  assign bus.rpi_tc_new       = r_tc_new;
  assign bus.ti_rdata         = r_rdata;
  assign bus.crubit           = r_crubit;
  assign bus.tipi_data_out    = r_oe_data;
  assign bus.tipi_control_out = r_oe_ctrl;
  assign bus.tipi_dsr_out     = r_oe_dsr;

endmodule

// File: tb/tb_tipi_mailbox_ctrl.sv
// Self-checking bench for tipi_mailbox_ctrl: scenario tasks drive TI/RPi
// stimulus; expected register data goes through a scoreboard queue.
`timescale 1ns/1ps
module tb_tipi_mailbox_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  tipi_mailbox_ctrl_if bus ();

  tipi_mailbox_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cru_write(input logic [15:0] a);
    @(negedge clk); bus.ti_a = a;
    @(negedge clk); bus.ti_cruclk = 1'b0;
    idle(4); bus.ti_cruclk = 1'b1;
    idle(4);
  endtask

  task automatic rpi_write(input logic sel, input logic [7:0] d);
    @(negedge clk); bus.rpi_wr = 1'b1; bus.rpi_sel = sel; bus.rpi_wdata = d;
    @(negedge clk); bus.rpi_wr = 1'b0;
  endtask

  // Returns at the negedge where ti_we has just been driven low.
  task automatic ti_write_begin(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); bus.ti_a = a; bus.ti_data = d; bus.ti_memen = 1'b0;
    @(negedge clk); bus.ti_we = 1'b0;
  endtask

  task automatic ti_write_end();
    bus.ti_we = 1'b1; bus.ti_memen = 1'b1;
    idle(5);
  endtask

  task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
    ti_write_begin(a, d);
    idle(6);
    ti_write_end();
  endtask

  task automatic ti_read_begin(input logic [15:0] a);
    @(negedge clk); bus.ti_a = a; bus.ti_memen = 1'b0; bus.ti_dbin = 1'b1;
    idle(4);
  endtask

  // Drops dbin and requires every OE* high within 3 clk.
  task automatic ti_read_end(input string nm);
    logic seen;
    seen = 1'b0;
    @(negedge clk); bus.ti_dbin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if ({bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out} === 3'b111) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (seen !== 1'b1)
      $display("FAIL %s_oe_release: got oe=%b, want 111 within 3 clk", nm,
               {bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out});
    else n_pass++;
    @(negedge clk); bus.ti_memen = 1'b1;
    idle(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_total++;
    if ({bus.crubit, bus.rpi_tc_new} !== 2'b00)
      $display("FAIL reset_flags: got crubit/tc_new=%b, want 00", {bus.crubit, bus.rpi_tc_new});
    else n_pass++;
    n_total++;
    if ({bus.rpi_td, bus.rpi_tc, bus.ti_rdata} !== 24'h000000)
      $display("FAIL reset_regs: got td/tc/rdata=%h, want 000000", {bus.rpi_td, bus.rpi_tc, bus.ti_rdata});
    else n_pass++;
    n_total++;
    if ({bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out} !== 3'b111)
      $display("FAIL reset_oe: got %b, want 111", {bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out});
    else n_pass++;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_cru();
    cru_write(16'h1201);
    n_total++;
    if (bus.crubit !== 1'b1) $display("FAIL cru_set: got %b, want 1", bus.crubit);
    else n_pass++;
    cru_write(16'h1200);
    n_total++;
    if (bus.crubit !== 1'b0) $display("FAIL cru_clear: got %b, want 0", bus.crubit);
    else n_pass++;
    cru_write(16'h1201);
    cru_write(16'h1300);
    n_total++;
    if (bus.crubit !== 1'b1) $display("FAIL cru_other_base: got %b, want 1", bus.crubit);
    else n_pass++;
    cru_write(16'h1200);
    cru_write(16'h1301);
    n_total++;
    if (bus.crubit !== 1'b0) $display("FAIL cru_1301_ignored: got %b, want 0", bus.crubit);
    else n_pass++;
    cru_write(16'h1201);
  endtask

  task automatic test_td_write();
    logic seen;
    seen = 1'b0;
    exp_q.push_back(8'hA5);
    ti_write_begin(16'h5FFF, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rpi_td === 8'hA5) begin seen = 1'b1; break; end
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL td_latency: got td=%h, want A5 within 4 clk", bus.rpi_td);
    else n_pass++;
    idle(6);
    ti_write_end();
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.rpi_td !== exp_v) $display("FAIL td_value: got %h, want %h", bus.rpi_td, exp_v);
    else n_pass++;
    cru_write(16'h1200);
    exp_q.push_back(8'hA5);
    ti_write(16'h5FFF, 8'h5A);
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.rpi_td !== exp_v) $display("FAIL td_disabled: got %h, want %h", bus.rpi_td, exp_v);
    else n_pass++;
    cru_write(16'h1201);
  endtask

  task automatic test_tc_handshake();
    exp_q.push_back(8'h3C);
    ti_write_begin(16'h5FFD, 8'h3C);
    idle(6);
    n_total++;
    if (bus.rpi_tc_new !== 1'b1) $display("FAIL tc_new_set: got %b, want 1", bus.rpi_tc_new);
    else n_pass++;
    // Ack while the strobe is still held: a second capture would re-set the flag.
    bus.rpi_tc_ack = 1'b1; @(negedge clk); bus.rpi_tc_ack = 1'b0;
    idle(4);
    ti_write_end();
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.rpi_tc !== exp_v) $display("FAIL tc_value: got %h, want %h", bus.rpi_tc, exp_v);
    else n_pass++;
    n_total++;
    if (bus.rpi_tc_new !== 1'b0) $display("FAIL tc_single_capture: got tc_new=%b, want 0", bus.rpi_tc_new);
    else n_pass++;
    // Ack coincident with the WRITE cycle of a new TC write.
    exp_q.push_back(8'hC3);
    ti_write_begin(16'h5FFD, 8'hC3);
    repeat (3) @(posedge clk);
    @(negedge clk); bus.rpi_tc_ack = 1'b1;
    @(negedge clk); bus.rpi_tc_ack = 1'b0;
    idle(4);
    ti_write_end();
    exp_v = exp_q.pop_front();
    n_total++;
    if ({bus.rpi_tc, bus.rpi_tc_new} !== {exp_v, 1'b1})
      $display("FAIL tc_ack_collision: got tc=%h new=%b, want tc=%h new=1", bus.rpi_tc, bus.rpi_tc_new, exp_v);
    else n_pass++;
  endtask

  task automatic test_rd_read();
    rpi_write(1'b0, 8'h77);
    exp_q.push_back(8'h77);
    ti_read_begin(16'h5FFB);
    n_total++;
    if ({bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out} !== 3'b011)
      $display("FAIL rd_oe: got %b, want 011", {bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out});
    else n_pass++;
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL rd_data: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
    rpi_write(1'b0, 8'h11);
    exp_q.push_back(8'h77);
    idle(2);
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL rd_frozen: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
    exp_q.push_back(8'h11);
    ti_read_end("rd");
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL rd_pending_applied: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    ti_read_begin(16'h5FFB);
    rpi_write(1'b0, 8'h22);
    rpi_write(1'b0, 8'h33);
    exp_q.push_back(8'h11);
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL b2b_frozen: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
    exp_q.push_back(8'h33);
    ti_read_end("b2b");
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL b2b_last_wins: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
  endtask

  task automatic test_rc_read();
    rpi_write(1'b1, 8'h99);
    exp_q.push_back(8'h99);
    ti_read_begin(16'h5FF9);
    n_total++;
    if ({bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out} !== 3'b101)
      $display("FAIL rc_oe: got %b, want 101", {bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out});
    else n_pass++;
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL rc_data: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
    ti_read_end("rc");
  endtask

  task automatic test_dsr_window();
    logic [15:0] addrs [4];
    logic [2:0]  oes   [4];
    addrs = '{16'h4000, 16'h5FF7, 16'h5FF8, 16'h3FFF};
    oes   = '{3'b110, 3'b110, 3'b111, 3'b111};
    for (int i = 0; i < 4; i++) begin
      ti_read_begin(addrs[i]);
      n_total++;
      if ({bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out} !== oes[i])
        $display("FAIL dsr_oe_%h: got %b, want %b", addrs[i],
                 {bus.tipi_data_out, bus.tipi_control_out, bus.tipi_dsr_out}, oes[i]);
      else n_pass++;
      ti_read_end("dsr");
    end
  endtask

  task automatic test_ti_reset();
    @(negedge clk); bus.ti_reset = 1'b0;
    idle(5);
    bus.ti_reset = 1'b1;
    idle(4);
    n_total++;
    if ({bus.crubit, bus.rpi_tc_new, bus.rpi_td, bus.rpi_tc} !== 18'h00000)
      $display("FAIL ti_reset_clear: got crubit=%b new=%b td=%h tc=%h, want 0 0 00 00",
               bus.crubit, bus.rpi_tc_new, bus.rpi_td, bus.rpi_tc);
    else n_pass++;
    cru_write(16'h1201);
    exp_q.push_back(8'h33);
    ti_read_begin(16'h5FFB);
    exp_v = exp_q.pop_front();
    n_total++;
    if (bus.ti_rdata !== exp_v) $display("FAIL ti_reset_rd_kept: got %h, want %h", bus.ti_rdata, exp_v);
    else n_pass++;
    ti_read_end("ti_reset");
  endtask

  initial begin
    bus.ti_a = 16'h0000; bus.ti_data = 8'h00;
    bus.ti_memen = 1'b1; bus.ti_we = 1'b1; bus.ti_dbin = 1'b0;
    bus.ti_cruclk = 1'b1; bus.ti_reset = 1'b1; bus.cru_base = 4'h2;
    bus.rpi_wr = 1'b0; bus.rpi_sel = 1'b0; bus.rpi_wdata = 8'h00; bus.rpi_tc_ack = 1'b0;
    test_reset();
    test_cru();
    test_td_write();
    test_tc_handshake();
    test_rd_read();
    test_back_to_back();
    test_rc_read();
    test_dsr_window();
    test_ti_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
